// File: rtl/serial_parity_frame_rx_pkg.sv
// Shared definitions for the serial parity frame receiver.
//   state_t     : receiver FSM states
//   DATA_W      : data bits per frame (matches the 4-bit parity checker)
//   FRAME_BITS  : start + data + parity + stop
//   clog2()     : ceiling log2, used to size the bit timer and bit counter
package serial_parity_frame_rx_pkg;

    localparam int unsigned DATA_W     = 4;
    localparam int unsigned FRAME_BITS = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/even_parity_bit_checker.sv
// Even-parity checker for a 4-bit nibble plus its parity bit.
// Ports:
//   a, b, c, d : data bits
//   p          : received parity bit
//   pec        : 1 when the five bits do not have even parity
module even_parity_bit_checker (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic p,
    output logic pec
);

    assign pec = a ^ b ^ c ^ d ^ p;

endmodule

// File: rtl/serial_parity_frame_rx.sv
// Single-wire frame receiver: start, DATA_W data bits LSB-first, even parity, stop.
// The captured frame is held in a valid/ready output register together with the
// parity-error flag from even_parity_bit_checker and a framing-error flag.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   rx_in      : serial line, idle high, already synchronous to clk
//   out_ready  : downstream accepts the held frame
//   out_valid  : output register holds a frame
//   data_out   : data nibble, bit 0 = first data bit on the line
//   par_out    : received parity bit
//   pec_out    : parity error (XOR of data and parity bits)
//   frame_err  : stop bit was sampled low
//   overrun    : one-cycle pulse when an unaccepted frame is overwritten
import serial_parity_frame_rx_pkg::*;

module serial_parity_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_W       = serial_parity_frame_rx_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              par_out,
    output logic              pec_out,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned TimerW  = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
    localparam int unsigned BitCntW = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);

    // First wait lands on the middle of the start bit; later waits are one full bit.
    localparam logic [TimerW-1:0]  HalfLoad = TimerW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TimerW-1:0]  FullLoad = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [BitCntW-1:0] LastBit  = BitCntW'(DATA_W - 1);

    state_t               state_q, state_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    data_sh_q, data_sh_d;
    logic                 par_sh_q, par_sh_d;
    logic                 load;
    logic                 timer_done;
    logic                 pec_calc;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 par_out_q, par_out_d;
    logic                 pec_out_q, pec_out_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    assign timer_done = (timer_q == '0);

    // Parity is checked on the captured bits, never on the live line.
    even_parity_bit_checker u_checker (
        .a   (data_sh_q[0]),
        .b   (data_sh_q[1]),
        .c   (data_sh_q[2]),
        .d   (data_sh_q[3]),
        .p   (par_sh_q),
        .pec (pec_calc)
    );

    // Receive FSM: next state, timer, bit counter and shift register.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        data_sh_d = data_sh_q;
        par_sh_d  = par_sh_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d = START;
                    timer_d = HalfLoad;
                end
            end

            START: begin
                if (timer_done) begin
                    if (rx_in) begin
                        // Line went back high before mid start bit: glitch.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        timer_d   = FullLoad;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end

            DATA: begin
                if (timer_done) begin
                    data_sh_d[bit_cnt_q] = rx_in;
                    timer_d              = FullLoad;
                    if (bit_cnt_q == LastBit) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end

            PARITY: begin
                if (timer_done) begin
                    par_sh_d = rx_in;
                    timer_d  = FullLoad;
                    state_d  = STOP;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end

            STOP: begin
                if (timer_done) begin
                    load    = 1'b1;
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output register with valid/ready handshake and overrun detection.
    always_comb begin
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        par_out_d   = par_out_q;
        pec_out_d   = pec_out_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;

        if (load) begin
            out_valid_d = 1'b1;
            data_out_d  = data_sh_q;
            par_out_d   = par_sh_q;
            pec_out_d   = pec_calc;
            frame_err_d = ~rx_in;
            // Overwriting a frame nobody took; a same-cycle transfer is not a loss.
            overrun_d   = out_valid_q & ~out_ready;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            data_sh_q   <= '0;
            par_sh_q    <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            par_out_q   <= 1'b0;
            pec_out_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            data_sh_q   <= data_sh_d;
            par_sh_q    <= par_sh_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            par_out_q   <= par_out_d;
            pec_out_q   <= pec_out_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign par_out   = par_out_q;
    assign pec_out   = pec_out_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/serial_parity_frame_rx.md
Name: serial_parity_frame_rx

Overview:
Serial receiver that sits directly upstream of the 4-bit even-parity checker.
- Deserializes a single-wire frame: start, 4 data bits LSB-first, even-parity bit, stop.
- Presents the data nibble and parity bit, together with the computed parity-error flag, through a valid/ready output register.
- Downstream consumers get checked nibbles; the line runs in the same clock domain as the consumers.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit; must be even and >= 2
DATA_W, 4, data bits per frame; fixed at 4 to match the parity checker

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
rx_in  input  1  serial line, idle high, synchronous to clk (no internal synchronizer)
out_ready  input  1  downstream accepts the held frame
out_valid  output  1  data_out/par_out/pec_out/frame_err hold a received frame
data_out  output  4  received data nibble, d0 = first data bit
par_out  output  1  received parity bit
pec_out  output  1  XOR of d0..d3 and parity; 1 = even-parity error
frame_err  output  1  stop bit sampled as 0
overrun  output  1  one-cycle pulse when an unaccepted frame is overwritten

Behaviour:
- Reset (async, any state): FSM = IDLE, counters = 0. All outputs = 0, including out_valid and overrun.
- FSM states and transitions:
  - IDLE: leave when rx_in sampled 0. Enter START and load the bit timer with CLKS_PER_BIT/2-1.
  - START: when the timer reaches 0, re-sample rx_in (mid start bit).
    - If rx_in = 1: false start, return to IDLE with no output change.
    - If rx_in = 0: enter DATA with bit_cnt = 0 and timer = CLKS_PER_BIT-1.
  - DATA: each timer expiry, shift rx_in into bit position bit_cnt, then reload the timer. After bit_cnt = 3 is sampled, enter PARITY.
  - PARITY: at timer expiry, capture the parity bit and enter STOP.
  - STOP: at timer expiry, sample the stop bit.
    - Load data_out, par_out, pec_out and frame_err (frame_err = ~rx_in).
    - Set out_valid and return to IDLE.
    - A new start edge is accepted from the very next cycle.
- Sample timing relative to the first cycle rx_in = 0 is seen in IDLE (cycle 0), with CLKS_PER_BIT = 4:
  - start bit: cycle 2
  - data bit k: cycle 2+4(k+1)
  - parity: cycle 22
  - stop: cycle 26
  - out_valid = 1 from cycle 27
- Output handshake:
  - Transfer occurs on a cycle where out_valid & out_ready are both 1; out_valid clears on the next cycle unless a new frame loads on that same cycle.
  - Outputs are stable while out_valid = 1 and out_ready = 0.
  - Frame completion on the same cycle as a transfer: the new frame loads, out_valid stays 1, no overrun.
  - Frame completion while out_valid = 1 and out_ready = 0: the new frame overwrites and overrun pulses high for 1 cycle.
- pec_out is computed combinationally from the captured bits and registered with them, so it is never a live view of rx_in.
- A framing error still delivers the frame, with frame_err = 1; the receiver does not resynchronize beyond returning to IDLE.
- rx_in held at 0 after a frame completes: treated as a new start, and re-validated at mid-bit.
- Reset asserted mid-frame: the partial frame is discarded and no output is produced.

Decomposition:
- Shared package:
  - state enum {IDLE, START, DATA, PARITY, STOP}
  - DATA_W = 4, FRAME_BITS = 7
  - timer width function clog2(CLKS_PER_BIT)
- Sub-module: instantiate the existing even_parity_bit_checker (a, b, c, d, p -> pec) on the shift-register contents to produce pec_out. Parity logic is not duplicated.

Test Plan:
1. Clean frame: data 4'b1011, par 1, stop 1, CLKS_PER_BIT = 4, out_ready = 1 -> at cycle 27 out_valid = 1, data_out = 4'hB, par_out = 1, pec_out = 0, frame_err = 0; out_valid = 0 at cycle 28.
2. Parity error: data 4'b0110, par 1 -> data_out = 4'h6, pec_out = 1, frame_err = 0.
3. Glitch: rx_in low for 1 cycle then high -> START re-sample sees 1, FSM back to IDLE, out_valid stays 0.
4. Bad stop: data 4'hF, par 0, stop 0 -> data_out = 4'hF, pec_out = 0, frame_err = 1.
5. Back-pressure: out_ready = 0, send 4'h3 then 4'hC -> outputs hold 4'h3 until the second frame completes, then overrun pulses 1 cycle with data_out = 4'hC; raising out_ready clears out_valid next cycle.
6. Reset at cycle 14 of a frame -> all outputs 0 immediately; the following full frame 4'h5, par 0 is received correctly.
